// File: rtl/if_id_skid_if.sv
// IF/ID handshake bundle: fetch-side offer, decode-side consume, and the
// decoded field view of the head entry.
interface if_id_skid_if;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [25:0] jaddr;
    logic [1:0]  level;

    // master: the fetch/decode environment around the buffer
    modport master (
        output in_instr, in_pc4, in_valid, out_ready, flush,
        input  in_ready, out_valid, out_instr, out_pc4,
        input  opcode, rs, rt, rd, shamt, funct, imm_sext, jaddr, level
    );

    // slave: the skid buffer itself
    modport slave (
        input  in_instr, in_pc4, in_valid, out_ready, flush,
        output in_ready, out_valid, out_instr, out_pc4,
        output opcode, rs, rt, rd, shamt, funct, imm_sext, jaddr, level
    );
endinterface

// File: rtl/if_id_skid.sv
// Two-entry IF/ID pipeline register with skid slot; state updates on the
// falling clock edge, in_ready is registered so decode stalls never reach fetch.
module if_id_skid (
    input  logic        clk,
    input  logic        rst,
    if_id_skid_if.slave bus
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } entry_t;

    entry_t main_q, skid_q;
    entry_t main_d, skid_d;
    entry_t in_e;
    logic   accept;
    logic   drain;
    logic [31:0] head_instr;
    logic [31:0] head_pc4;

    always_comb begin
        in_e       = '0;
        in_e.instr = bus.in_instr;
        in_e.pc4   = bus.in_pc4;
        in_e.valid = 1'b1;
    end

    // flush kills the offered word as well as the held ones
    assign accept = bus.in_valid & ~skid_q.valid & ~bus.flush;
    assign drain  = main_q.valid & bus.out_ready;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (bus.flush) begin
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!main_q.valid) begin
            if (accept)
                main_d = in_e;
        end else if (drain) begin
            if (skid_q.valid) begin
                main_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (accept) begin
                main_d = in_e;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (accept) begin
            skid_d = in_e;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // stale data in an empty main slot must never leak out
    assign head_instr = main_q.valid ? main_q.instr : 32'h0;
    assign head_pc4   = main_q.valid ? main_q.pc4   : 32'h0;

    assign bus.in_ready  = ~skid_q.valid;
    assign bus.out_valid = main_q.valid;
    assign bus.out_instr = head_instr;
    assign bus.out_pc4   = head_pc4;
    assign bus.opcode    = head_instr[31:26];
    assign bus.rs        = head_instr[25:21];
    assign bus.rt        = head_instr[20:16];
    assign bus.rd        = head_instr[15:11];
    assign bus.shamt     = head_instr[10:6];
    assign bus.funct     = head_instr[5:0];
    assign bus.imm_sext  = {{16{head_instr[15]}}, head_instr[15:0]};
    assign bus.jaddr     = head_instr[25:0];
    assign bus.level     = {1'b0, main_q.valid} + {1'b0, skid_q.valid};
endmodule
